hazard_stall_unit: RTL and testbench

Pipeline hazard controller for the RV32IM 5-stage core; the stall/flush side of the forwarding unit. Forwarding resolves every RAW dependency that can be satisfied by a bypass path. This block handles the dependencies that cannot be bypassed, plus control hazards:
- **Load-use:** stalls fetch/decode and injects a bubble into EX.
- **Multi-cycle DIV/REM:** holds EX for a fixed latency.
- **Taken branch/jump:** flushes the wrong-path instructions.

It also keeps a running count of stall cycles.

---
 rtl/hazard_stall_unit.sv | 196 +++++++++++++++++++
 tb/tb_hazard_stall_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_unit.sv
// ============================================================================
// hazard_stall_unit
//
// Stall/flush controller for the RV32IM 5-stage pipeline. Bypassing handles
// every RAW dependency it can. This block handles the rest:
//   - load-use: holds PC and IF/ID, and loads a bubble into ID/EX for one cycle
//   - multi-cycle DIV/REM: holds the front of the pipe while EX works
//   - taken branch/jump: squashes the wrong-path IF/ID and ID/EX contents
// It also counts the cycles in which the PC was held.
//
// Optional feature macro: HAZARD_DIV_STALL_EN
//   defined   -> divide stalling (IDLE/BUSY FSM plus 8-bit CNT) is built in
//   undefined -> EXE_IS_DIV and DIV_CYCLES are ignored, and IDEX_STALL,
//                EXMEM_BUBBLE and DIV_DONE are tied 0 (single-cycle divider)
//
// Parameter:
//   DIV_CYCLES   cycles a DIV/DIVU/REM/REMU spends in EX (legal 3..255)
// Ports:
//   CLK, RESET      clock, synchronous active-high reset
//   ID_ADDR1/2      rs1/rs2 of the instruction in ID
//   ID_USES1/2      the ID instruction reads rs1/rs2
//   ID_IS_STORE     the ID instruction is a store (rs2 is store data)
//   EXE_ADDR        rd of the instruction in EX
//   EXE_MEMREAD     the EX instruction is a load
//   EXE_IS_DIV      the EX instruction is a divide/remainder
//   BRANCH_TAKEN    EX resolved a taken branch or jump
//   PC_STALL, IFID_STALL, IFID_FLUSH, IDEX_STALL, IDEX_BUBBLE, EXMEM_BUBBLE
//                   pipeline control, Mealy (take effect at the same edge)
//   DIV_DONE        the divide result is valid in EX this cycle
//   STALL_COUNT     registered count of cycles with PC_STALL=1 (wraps)
// ============================================================================
module hazard_stall_unit #(
    parameter int DIV_CYCLES = 33
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [4:0]  ID_ADDR1,
    input  logic [4:0]  ID_ADDR2,
    input  logic        ID_USES1,
    input  logic        ID_USES2,
    input  logic        ID_IS_STORE,
    input  logic [4:0]  EXE_ADDR,
    input  logic        EXE_MEMREAD,
    input  logic        EXE_IS_DIV,
    input  logic        BRANCH_TAKEN,
    output logic        PC_STALL,
    output logic        IFID_STALL,
    output logic        IFID_FLUSH,
    output logic        IDEX_STALL,
    output logic        IDEX_BUBBLE,
    output logic        EXMEM_BUBBLE,
    output logic        DIV_DONE,
    output logic [31:0] STALL_COUNT
);

    logic        w_lu;
    logic        w_pc_stall;
    logic        w_ifid_stall;
    logic        w_ifid_flush;
    logic        w_idex_stall;
    logic        w_idex_bubble;
    logic        w_exmem_bubble;
    logic        w_div_done;
    logic [31:0] r_stall_count;

    // A store whose only match is on rs2 (store data) is covered by the
    // MEM-stage forward, so only its rs1 (address base) can cause a stall.
    // Loads to x0 never create a dependency.
    assign w_lu = EXE_MEMREAD && (EXE_ADDR != 5'd0) &&
                  ((ID_USES1 && (ID_ADDR1 == EXE_ADDR)) ||
                   (ID_USES2 && (ID_ADDR2 == EXE_ADDR) && !ID_IS_STORE));

`ifdef HAZARD_DIV_STALL_EN

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_next;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= IDLE;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the if/case leaves a signal unassigned and no latch appears.
    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_pc_stall     = 1'b0;
        w_ifid_stall   = 1'b0;
        w_ifid_flush   = 1'b0;
        w_idex_stall   = 1'b0;
        w_idex_bubble  = 1'b0;
        w_exmem_bubble = 1'b0;
        w_div_done     = 1'b0;
        if (!RESET) begin
            unique case (r_state)
                IDLE: begin
                    if (BRANCH_TAKEN) begin
                        // Squashing the ID instruction also removes its hazard.
                        w_ifid_flush  = 1'b1;
                        w_idex_bubble = 1'b1;
                    end else if (EXE_IS_DIV) begin
                        w_pc_stall     = 1'b1;
                        w_ifid_stall   = 1'b1;
                        w_idex_stall   = 1'b1;
                        w_exmem_bubble = 1'b1;
                        // This cycle and DIV_CYCLES-2 more in BUSY stall; the
                        // cycle where CNT reaches 0 delivers the result.
                        w_cnt_next     = 8'(DIV_CYCLES - 2);
                        w_state_next   = BUSY;
                    end else if (w_lu) begin
                        w_pc_stall    = 1'b1;
                        w_ifid_stall  = 1'b1;
                        w_idex_bubble = 1'b1;
                    end
                end
                BUSY: begin
                    // Branch and load-use are ignored: EX still holds the divide.
                    if (r_cnt != 8'd0) begin
                        w_pc_stall     = 1'b1;
                        w_ifid_stall   = 1'b1;
                        w_idex_stall   = 1'b1;
                        w_exmem_bubble = 1'b1;
                        w_cnt_next     = r_cnt - 8'd1;
                    end else begin
                        w_div_done   = 1'b1;
                        w_state_next = IDLE;
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

`else

    // Divider is single-cycle: the divide inputs are deliberately unused.
    logic w_unused_div;
    assign w_unused_div = ^{EXE_IS_DIV, 8'(DIV_CYCLES), CLK};

    always_comb begin
        w_pc_stall     = 1'b0;
        w_ifid_stall   = 1'b0;
        w_ifid_flush   = 1'b0;
        w_idex_stall   = 1'b0;
        w_idex_bubble  = 1'b0;
        w_exmem_bubble = 1'b0;
        w_div_done     = 1'b0;
        if (!RESET) begin
            if (BRANCH_TAKEN) begin
                w_ifid_flush  = 1'b1;
                w_idex_bubble = 1'b1;
            end else if (w_lu) begin
                w_pc_stall    = 1'b1;
                w_ifid_stall  = 1'b1;
                w_idex_bubble = 1'b1;
            end
        end
    end

`endif

    // w_pc_stall is already 0 while RESET is high, so reset simply clears.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_stall_count <= 32'd0;
        end else if (w_pc_stall) begin
            r_stall_count <= r_stall_count + 32'd1;
        end
    end

    assign PC_STALL     = w_pc_stall;
    assign IFID_STALL   = w_ifid_stall;
    assign IFID_FLUSH   = w_ifid_flush;
    assign IDEX_STALL   = w_idex_stall;
    assign IDEX_BUBBLE  = w_idex_bubble;
    assign EXMEM_BUBBLE = w_exmem_bubble;
    assign DIV_DONE     = w_div_done;
    // Every output reads 0 during a reset cycle, the counter included.
    assign STALL_COUNT  = RESET ? 32'd0 : r_stall_count;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// ============================================================================
// tb_hazard_stall_unit
//
// Directed-vector bench for hazard_stall_unit with DIV_CYCLES=4. Inputs change
// on the falling edge and outputs are sampled 1 ns later, well away from the
// rising edge. Expected values are hand-computed; divide expectations depend
// on whether HAZARD_DIV_STALL_EN is defined for the build.
//
// Output vector bit order: {PC_STALL, IFID_STALL, IFID_FLUSH, IDEX_STALL,
//                           IDEX_BUBBLE, EXMEM_BUBBLE, DIV_DONE}
// ============================================================================
module tb_hazard_stall_unit;

    localparam logic [6:0] O_NONE = 7'b0000000;
    localparam logic [6:0] O_LU   = 7'b1100100;
    localparam logic [6:0] O_BR   = 7'b0010100;
`ifdef HAZARD_DIV_STALL_EN
    localparam logic [6:0] O_DIV  = 7'b1101010;
    localparam logic [6:0] O_DONE = 7'b0000001;
    localparam logic [6:0] O_BUSY_LU = 7'b1101010;   // load-use ignored in BUSY
    localparam int         DIV_STALLS = 3;
    localparam int         BUSY_LU_STALLS = 3;
`else
    localparam logic [6:0] O_DIV  = 7'b0000000;
    localparam logic [6:0] O_DONE = 7'b0000000;
    localparam logic [6:0] O_BUSY_LU = 7'b1100100;   // plain load-use
    localparam int         DIV_STALLS = 0;
    localparam int         BUSY_LU_STALLS = 1;
`endif

    logic        CLK;
    logic        RESET;
    logic [4:0]  ID_ADDR1;
    logic [4:0]  ID_ADDR2;
    logic        ID_USES1;
    logic        ID_USES2;
    logic        ID_IS_STORE;
    logic [4:0]  EXE_ADDR;
    logic        EXE_MEMREAD;
    logic        EXE_IS_DIV;
    logic        BRANCH_TAKEN;
    logic        PC_STALL;
    logic        IFID_STALL;
    logic        IFID_FLUSH;
    logic        IDEX_STALL;
    logic        IDEX_BUBBLE;
    logic        EXMEM_BUBBLE;
    logic        DIV_DONE;
    logic [31:0] STALL_COUNT;

    int n_vec;
    int n_err;

    logic [6:0] w_outs;
    assign w_outs = {PC_STALL, IFID_STALL, IFID_FLUSH, IDEX_STALL,
                     IDEX_BUBBLE, EXMEM_BUBBLE, DIV_DONE};

    hazard_stall_unit #(.DIV_CYCLES(4)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .ID_ADDR1     (ID_ADDR1),
        .ID_ADDR2     (ID_ADDR2),
        .ID_USES1     (ID_USES1),
        .ID_USES2     (ID_USES2),
        .ID_IS_STORE  (ID_IS_STORE),
        .EXE_ADDR     (EXE_ADDR),
        .EXE_MEMREAD  (EXE_MEMREAD),
        .EXE_IS_DIV   (EXE_IS_DIV),
        .BRANCH_TAKEN (BRANCH_TAKEN),
        .PC_STALL     (PC_STALL),
        .IFID_STALL   (IFID_STALL),
        .IFID_FLUSH   (IFID_FLUSH),
        .IDEX_STALL   (IDEX_STALL),
        .IDEX_BUBBLE  (IDEX_BUBBLE),
        .EXMEM_BUBBLE (EXMEM_BUBBLE),
        .DIV_DONE     (DIV_DONE),
        .STALL_COUNT  (STALL_COUNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Move to the next cycle's input window and return all inputs to idle.
    task automatic next_cycle();
        @(negedge CLK);
        ID_ADDR1     = 5'd0;
        ID_ADDR2     = 5'd0;
        ID_USES1     = 1'b0;
        ID_USES2     = 1'b0;
        ID_IS_STORE  = 1'b0;
        EXE_ADDR     = 5'd0;
        EXE_MEMREAD  = 1'b0;
        EXE_IS_DIV   = 1'b0;
        BRANCH_TAKEN = 1'b0;
    endtask

    // lw r1 in EX, "add r3,r2,r1" in ID: rs2 matches.
    task automatic set_lu();
        EXE_MEMREAD = 1'b1;
        EXE_ADDR    = 5'd1;
        ID_ADDR1    = 5'd2;
        ID_USES1    = 1'b1;
        ID_ADDR2    = 5'd1;
        ID_USES2    = 1'b1;
    endtask

    task automatic chk(input string tag, input logic [6:0] exp_outs, input int exp_cnt);
        #1;
        check({tag, ".outs"}, 32'(w_outs), 32'(exp_outs));
        check({tag, ".cnt"},  STALL_COUNT, 32'(exp_cnt));
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        RESET = 1'b1;

        // Reset with a live load-use hazard on the inputs: everything 0.
        next_cycle();
        set_lu();
        chk("reset0", O_NONE, 0);
        next_cycle();
        set_lu();
        chk("reset1", O_NONE, 0);

        next_cycle();
        RESET = 1'b0;
        chk("idle", O_NONE, 0);

        // Load-use: exactly one stall cycle, counter 0 -> 1.
        next_cycle(); set_lu();
        chk("lu", O_LU, 0);
        next_cycle();
        chk("lu_after", O_NONE, 1);

        // sw r1,8(r3): rs2-only match on a store does not stall.
        next_cycle();
        EXE_MEMREAD = 1'b1; EXE_ADDR = 5'd1;
        ID_IS_STORE = 1'b1; ID_ADDR1 = 5'd3; ID_USES1 = 1'b1;
        ID_ADDR2 = 5'd1; ID_USES2 = 1'b1;
        chk("st_data", O_NONE, 1);
        // sw rX,8(r1): base-register match does stall.
        next_cycle();
        EXE_MEMREAD = 1'b1; EXE_ADDR = 5'd1;
        ID_IS_STORE = 1'b1; ID_ADDR1 = 5'd1; ID_USES1 = 1'b1;
        ID_ADDR2 = 5'd1; ID_USES2 = 1'b1;
        chk("st_base", O_LU, 1);
        next_cycle();
        chk("st_after", O_NONE, 2);

        // Load to x0 never stalls.
        next_cycle();
        EXE_MEMREAD = 1'b1; EXE_ADDR = 5'd0; ID_ADDR1 = 5'd0; ID_USES1 = 1'b1;
        chk("x0", O_NONE, 2);
        // Matching address on an operand the instruction does not read.
        next_cycle();
        EXE_MEMREAD = 1'b1; EXE_ADDR = 5'd7; ID_ADDR1 = 5'd7; ID_ADDR2 = 5'd7;
        chk("no_use", O_NONE, 2);
        // Matching address but the EX instruction is not a load.
        next_cycle();
        EXE_ADDR = 5'd7; ID_ADDR1 = 5'd7; ID_USES1 = 1'b1;
        chk("no_load", O_NONE, 2);
        // rs1 match on a non-store.
        next_cycle();
        EXE_MEMREAD = 1'b1; EXE_ADDR = 5'd31; ID_ADDR1 = 5'd31; ID_USES1 = 1'b1;
        chk("lu_rs1", O_LU, 2);

        // Branch beats load-use; no counter change afterwards.
        next_cycle(); set_lu(); BRANCH_TAKEN = 1'b1;
        chk("br_lu", O_BR, 3);
        next_cycle();
        chk("br_after", O_NONE, 3);

        // Divide at t (DIV_CYCLES=4); a load-use appears at t+1 while busy.
        next_cycle(); EXE_IS_DIV = 1'b1;
        chk("div_t0", O_DIV, 3);
        next_cycle(); EXE_IS_DIV = 1'b1; set_lu();
        chk("div_t1", O_BUSY_LU, 3 + (DIV_STALLS > 0 ? 1 : 0));
        next_cycle(); EXE_IS_DIV = 1'b1;
        chk("div_t2", O_DIV, 3 + (DIV_STALLS > 0 ? 2 : BUSY_LU_STALLS));
        next_cycle(); EXE_IS_DIV = 1'b1;
        chk("div_t3", O_DONE, 3 + BUSY_LU_STALLS);
        next_cycle();
        chk("div_t4", O_NONE, 3 + BUSY_LU_STALLS);

        // Reset mid-divide aborts it; a later divide runs in full.
        next_cycle(); EXE_IS_DIV = 1'b1;
        chk("rdiv_t0", O_DIV, 3 + BUSY_LU_STALLS);
        next_cycle(); EXE_IS_DIV = 1'b1; RESET = 1'b1;
        chk("rdiv_t1", O_NONE, 0);
        next_cycle(); RESET = 1'b0;
        chk("rdiv_t2", O_NONE, 0);
        next_cycle(); EXE_IS_DIV = 1'b1;
        chk("rdiv_t3", O_DIV, 0);
        next_cycle(); EXE_IS_DIV = 1'b1;
        chk("rdiv_t4", O_DIV, DIV_STALLS > 0 ? 1 : 0);
        next_cycle(); EXE_IS_DIV = 1'b1;
        chk("rdiv_t5", O_DIV, DIV_STALLS > 0 ? 2 : 0);
        next_cycle(); EXE_IS_DIV = 1'b1;
        chk("rdiv_t6", O_DONE, DIV_STALLS);
        next_cycle();
        chk("rdiv_t7", O_NONE, DIV_STALLS);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
